// File: rtl/dispatch4_rr_pkg.sv
// Shared constants and target-search helper for the dispatch4_rr round-robin dispatcher.
package dispatch4_rr_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LANES-1:0] lane_mask_t;

    // First non-full lane in rotation order starting at ptr; returns ptr when every lane is full.
    function automatic ptr_t first_free(input ptr_t ptr, input lane_mask_t full);
        ptr_t idx;
        first_free = ptr;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (!full[idx]) begin
                first_free = idx;
            end
        end
    endfunction

endpackage

// File: rtl/DMux4Way.sv
// One-bit 1-to-4 demultiplexer: routes in onto the output selected by sel.
module DMux4Way (
    input  logic       in,
    input  logic [1:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);

    assign a = in & (sel == 2'd0);
    assign b = in & (sel == 2'd1);
    assign c = in & (sel == 2'd2);
    assign d = in & (sel == 2'd3);

endmodule

// File: rtl/dispatch4_rr.sv
// Round-robin dispatcher: one valid/ready word stream onto four one-entry lane buffers.
// DISPATCH4_SKIP_EN: when defined, busy lanes are skipped; otherwise strict rotation.
module dispatch4_rr
    import dispatch4_rr_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [PTR_W-1:0] sel,
    output logic [CNT_W-1:0] accept_cnt
);

    logic [LANES-1:0] r_full;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data [LANES];

    logic [PTR_W-1:0] w_tgt;
    logic             w_ready;
    logic             w_accept;
    logic [LANES-1:0] w_load;
    logic [LANES-1:0] w_drain;

    // Target lane and readiness depend only on registered state, never on in_valid/out_ready.
    always_comb begin
        w_tgt   = r_ptr;
        w_ready = 1'b0;
`ifdef DISPATCH4_SKIP_EN
        w_tgt   = first_free(r_ptr, r_full);
        w_ready = ~&r_full;
`else
        w_ready = ~r_full[r_ptr];
`endif
    end

    assign w_accept = in_valid & w_ready;
    assign w_drain  = r_full & out_ready;

    DMux4Way u_dmux (
        .in  (w_accept),
        .sel (w_tgt),
        .a   (w_load[0]),
        .b   (w_load[1]),
        .c   (w_load[2]),
        .d   (w_load[3])
    );

    // Loads only hit non-full lanes, so a lane never sees load and drain together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                    r_full[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (|w_load) begin
                r_ptr <= w_tgt + PTR_W'(1);
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_full;
    assign out_data0  = r_data[0];
    assign out_data1  = r_data[1];
    assign out_data2  = r_data[2];
    assign out_data3  = r_data[3];
    assign sel        = r_ptr;
    assign accept_cnt = r_cnt;

endmodule

// File: tb/tb_dispatch4_rr.sv
// Directed bench for dispatch4_rr: vector table plus hand-written multi-cycle sequences.
module tb_dispatch4_rr;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0]  sel;
    logic [7:0]  accept_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dispatch4_rr #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .sel        (sel),
        .accept_cnt (accept_cnt)
    );

    typedef struct {
        logic        v;
        logic [3:0]  ro;
        logic [15:0] d;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_cnt;
        int          lane;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_data(input int l);
        case (l)
            0:       lane_data = out_data0;
            1:       lane_data = out_data1;
            2:       lane_data = out_data2;
            default: lane_data = out_data3;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] ro, input logic [15:0] d);
        in_valid  = v;
        out_ready = ro;
        in_data   = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [3:0] ev, input logic [1:0] es,
                             input logic [7:0] ec);
        chk({name, "_valid"}, 32'(out_valid), 32'(ev));
        chk({name, "_sel"}, 32'(sel), 32'(es));
        chk({name, "_cnt"}, 32'(accept_cnt), 32'(ec));
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 16'h0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'b0000, 16'h0000);

        //            v  ro       d        rdy  valid    sel cnt lane data
        vecs[0]  = '{1'b1, 4'b0000, 16'h0011, 1'b1, 4'b0001, 2'd1, 8'd1,  0, 16'h0011};
        vecs[1]  = '{1'b1, 4'b0000, 16'h0022, 1'b1, 4'b0011, 2'd2, 8'd2,  1, 16'h0022};
        vecs[2]  = '{1'b1, 4'b0000, 16'h0033, 1'b1, 4'b0111, 2'd3, 8'd3,  2, 16'h0033};
        vecs[3]  = '{1'b1, 4'b0000, 16'h0044, 1'b1, 4'b1111, 2'd0, 8'd4,  3, 16'h0044};
        vecs[4]  = '{1'b1, 4'b0000, 16'h0055, 1'b0, 4'b1111, 2'd0, 8'd4,  0, 16'h0011};
        vecs[5]  = '{1'b0, 4'b0001, 16'h0000, 1'b0, 4'b1110, 2'd0, 8'd4,  0, 16'h0011};
        vecs[6]  = '{1'b1, 4'b0010, 16'h0066, 1'b1, 4'b1101, 2'd1, 8'd5,  0, 16'h0066};
        vecs[7]  = '{1'b1, 4'b0000, 16'h0077, 1'b1, 4'b1111, 2'd2, 8'd6,  1, 16'h0077};
        vecs[8]  = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0000, 2'd2, 8'd6,  1, 16'h0077};
        vecs[9]  = '{1'b1, 4'b1111, 16'h0100, 1'b1, 4'b0100, 2'd3, 8'd7,  2, 16'h0100};
        vecs[10] = '{1'b1, 4'b1111, 16'h0101, 1'b1, 4'b1000, 2'd0, 8'd8,  3, 16'h0101};
        vecs[11] = '{1'b1, 4'b1111, 16'h0102, 1'b1, 4'b0001, 2'd1, 8'd9,  0, 16'h0102};
        vecs[12] = '{1'b1, 4'b1111, 16'h0103, 1'b1, 4'b0010, 2'd2, 8'd10, 1, 16'h0103};
        vecs[13] = '{1'b0, 4'b0000, 16'hFFFF, 1'b1, 4'b0010, 2'd2, 8'd10, 2, 16'h0100};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk_state("reset", 4'b0000, 2'd0, 8'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_data", {out_data0, out_data1} | {out_data2, out_data3}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].ro, vecs[i].d);
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sel, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_data", i), 32'(lane_data(vecs[i].lane)), 32'(vecs[i].exp_data));
        end

        // Lane 1 busy with ptr=1: skip vs strict behaviour
        do_reset();
        drive(1'b1, 4'b0000, 16'h00A1); tick();
        drive(1'b1, 4'b0001, 16'h00A2); tick();
        drive(1'b1, 4'b0000, 16'h00A3); tick();
        drive(1'b1, 4'b0100, 16'h00A4); tick();
        drive(1'b1, 4'b1000, 16'h00A5); tick();
        drive(1'b0, 4'b0001, 16'h0000); tick();
        chk_state("busy_setup", 4'b0010, 2'd1, 8'd5);
        drive(1'b1, 4'b0000, 16'hBEEF);
`ifdef DISPATCH4_SKIP_EN
        chk("skip_ready", 32'(in_ready), 32'd1);
        tick();
        chk_state("skip", 4'b0110, 2'd3, 8'd6);
        chk("skip_data", 32'(out_data2), 32'h0000BEEF);
`else
        chk("strict_ready0", 32'(in_ready), 32'd0);
        tick();
        chk_state("strict_stall0", 4'b0010, 2'd1, 8'd5);
        chk("strict_ready1", 32'(in_ready), 32'd0);
        tick();
        chk_state("strict_stall1", 4'b0010, 2'd1, 8'd5);
        drive(1'b1, 4'b0010, 16'hBEEF);
        chk("strict_no_bypass", 32'(in_ready), 32'd0);
        tick();
        chk_state("strict_drain", 4'b0000, 2'd1, 8'd5);
        drive(1'b1, 4'b0000, 16'hBEEF);
        chk("strict_ready2", 32'(in_ready), 32'd1);
        tick();
        chk_state("strict_fill", 4'b0010, 2'd2, 8'd6);
        chk("strict_data", 32'(out_data1), 32'h0000BEEF);
`endif

        // Same-cycle drain of lane 0 and fill of lane 2, then reset with 1011 buffered
        do_reset();
        drive(1'b1, 4'b0000, 16'h0C01); tick();
        drive(1'b1, 4'b0000, 16'h0C02); tick();
        chk_state("dfill_pre", 4'b0011, 2'd2, 8'd2);
        drive(1'b1, 4'b0001, 16'h0C03); tick();
        chk_state("dfill", 4'b0110, 2'd3, 8'd3);
        chk("dfill_data", 32'(out_data2), 32'h00000C03);
        drive(1'b1, 4'b0000, 16'h0C04); tick();
        drive(1'b1, 4'b0100, 16'h0C05); tick();
        chk_state("rst_pre", 4'b1011, 2'd1, 8'd5);
        drive(1'b1, 4'b1111, 16'h0C06);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("rst_mid", 4'b0000, 2'd0, 8'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_data", {out_data0, out_data1} | {out_data2, out_data3}, 32'd0);

        // 256 back-to-back accepts with every lane draining
        do_reset();
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 4'b1111, 16'(k * 3 + 1));
            chk($sformatf("wrap%0d_ready", k), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("wrap%0d_state", k),
                32'({out_valid, sel, lane_data(k % 4)}),
                32'({4'(1 << (k % 4)), 2'((k + 1) % 4), 16'(k * 3 + 1)}));
        end
        drive(1'b0, 4'b1111, 16'h0000);
        chk_state("wrap_end", 4'b1000, 2'd0, 8'd0);
        tick();
        chk_state("wrap_drained", 4'b0000, 2'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
